elevator_controller: RTL and testbench

//  Car-motion FSM for the 7-stop EEB elevator (1, 2, 2M, 3, 3M, 4, 4M; encoded 0..6).

---
 rtl/elevator_controller.sv | 159 +++++++++++++++
 tb/tb_elevator_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_controller.sv
// Car-motion controller for a multi-stop elevator: latches calls, steps the car
// one floor per travel period, holds the door, and serves calls in SCAN order.
module elevator_controller #(
  parameter int unsigned NUM_FLOORS    = 7,
  parameter int unsigned TRAVEL_CYCLES = 50000000,
  parameter int unsigned DOOR_CYCLES   = 100000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [2:0]            currentFl,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  moving_up,
  output logic                  moving_dn
);

  localparam int unsigned TIMER_W = 32;
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [2:0]           cur_n;
  logic [2:0]           step_fl;
  logic                 dir_up, dir_up_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [NUM_FLOORS-1:0] req, pending_n;
  logic                 above, below;

  // One-hot mask of a floor code; codes outside the floor range give zero.
  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [2:0] fl);
    floor_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (3'(i) == fl) floor_mask[i] = 1'b1;
    end
  endfunction

  assign req = pending | call_req;

  // Outstanding requests strictly above / below the car.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (req[i] && (3'(i) > currentFl)) above = 1'b1;
      if (req[i] && (3'(i) < currentFl)) below = 1'b1;
    end
  end

  // Next-state, floor, direction, timer and call-latch logic.
  always_comb begin
    state_n   = state;
    cur_n     = currentFl;
    dir_up_n  = dir_up;
    timer_n   = timer;
    step_fl   = currentFl;
    pending_n = pending | call_req;

    case (state)
      IDLE: begin
        if (|(req & floor_mask(currentFl))) begin
          state_n = DOOR_OPEN;
          timer_n = DOOR_LOAD;
        end else if (above) begin
          state_n  = MOVE_UP;
          dir_up_n = 1'b1;
          timer_n  = TRAVEL_LOAD;
        end else if (below) begin
          state_n  = MOVE_DOWN;
          dir_up_n = 1'b0;
          timer_n  = TRAVEL_LOAD;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (timer == '0) begin
          step_fl = (state == MOVE_UP) ? currentFl + 3'd1 : currentFl - 3'd1;
          cur_n   = step_fl;
          if (|(req & floor_mask(step_fl))) begin
            state_n = DOOR_OPEN;
            timer_n = DOOR_LOAD;
          end else begin
            timer_n = TRAVEL_LOAD;
          end
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end

      DOOR_OPEN: begin
        if (|(call_req & floor_mask(currentFl))) begin
          timer_n = DOOR_LOAD;
        end else if (timer == '0) begin
          if (dir_up) begin
            if (above) begin
              state_n = MOVE_UP;
              timer_n = TRAVEL_LOAD;
            end else if (below) begin
              state_n  = MOVE_DOWN;
              dir_up_n = 1'b0;
              timer_n  = TRAVEL_LOAD;
            end else begin
              state_n = IDLE;
            end
          end else begin
            if (below) begin
              state_n = MOVE_DOWN;
              timer_n = TRAVEL_LOAD;
            end else if (above) begin
              state_n  = MOVE_UP;
              dir_up_n = 1'b1;
              timer_n  = TRAVEL_LOAD;
            end else begin
              state_n = IDLE;
            end
          end
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase

    // The floor whose door is (or is about to be) open is being served.
    if (state_n == DOOR_OPEN) pending_n = pending_n & ~floor_mask(cur_n);
  end

  // State, car position and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      currentFl <= 3'd0;
      pending   <= '0;
      dir_up    <= 1'b1;
      timer     <= '0;
      door_open <= 1'b0;
      moving_up <= 1'b0;
      moving_dn <= 1'b0;
    end else begin
      state     <= state_n;
      currentFl <= cur_n;
      pending   <= pending_n;
      dir_up    <= dir_up_n;
      timer     <= timer_n;
      door_open <= (state_n == DOOR_OPEN);
      moving_up <= (state_n == MOVE_UP);
      moving_dn <= (state_n == MOVE_DOWN);
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller: expected door openings (floor,
// opening edge, open length) are queued when calls are driven and checked by
// a monitor each time the door closes.
module tb_elevator_controller;

  localparam int NF = 7;
  localparam int TC = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NF-1:0] call_req = '0;
  logic [2:0]    currentFl;
  logic [NF-1:0] pending;
  logic          door_open, moving_up, moving_dn;

  typedef struct {
    logic [2:0] floor;
    int         rise;
    int         len;
  } door_exp_t;

  door_exp_t sb[$];
  int        cyc = 0;
  int        tests = 0;
  int        fails = 0;

  elevator_controller #(
    .NUM_FLOORS(NF),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .call_req(call_req),
    .currentFl(currentFl),
    .pending(pending),
    .door_open(door_open),
    .moving_up(moving_up),
    .moving_dn(moving_dn)
  );

  always #5 clk = ~clk;

  // Rising-edge counter: at a negedge, cyc is the number of the last edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Door monitor: records each opening and checks it against the scoreboard on closing.
  logic       door_prev = 1'b0;
  int         rise_edge = 0;
  logic [2:0] rise_floor = 3'd0;
  always @(negedge clk) begin
    if (!reset_n) begin
      door_prev = 1'b0;
    end else begin
      if (door_open && !door_prev) begin
        rise_edge  = cyc;
        rise_floor = currentFl;
      end
      if (!door_open && door_prev) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL door_unexpected: opened at floor %0d edge %0d, none expected", rise_floor, rise_edge);
        end else begin
          door_exp_t e;
          e = sb.pop_front();
          if (rise_floor !== e.floor) begin
            fails++;
            $display("FAIL door_floor: got %0d expected %0d", rise_floor, e.floor);
          end
          tests++;
          if (rise_edge !== e.rise) begin
            fails++;
            $display("FAIL door_rise_edge: got %0d expected %0d (floor %0d)", rise_edge, e.rise, e.floor);
          end
          tests++;
          if ((cyc - rise_edge) !== e.len) begin
            fails++;
            $display("FAIL door_length: got %0d expected %0d (floor %0d)", cyc - rise_edge, e.len, e.floor);
          end
        end
      end
      door_prev = door_open;
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    call_req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !door_open && !moving_up && !moving_dn) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: queue=%0d door=%b up=%b dn=%b", name, sb.size(), door_open, moving_up, moving_dn);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++;
    if ({currentFl, pending, door_open, moving_up, moving_dn} !== '0) begin
      fails++;
      $display("FAIL reset_state: fl=%0d pend=%b door=%b up=%b dn=%b expected all 0",
               currentFl, pending, door_open, moving_up, moving_dn);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if ({currentFl, pending, door_open, moving_up, moving_dn} !== '0) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: fl=%0d pend=%b door=%b up=%b dn=%b expected all 0",
                 i, currentFl, pending, door_open, moving_up, moving_dn);
      end
    end
  endtask

  task automatic test_call_here();
    int n;
    @(negedge clk);
    call_req = 7'b0000001;
    n = cyc + 1;
    sb.push_back('{floor: 3'd0, rise: n, len: DC});
    @(negedge clk);
    call_req = '0;
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (pending !== 7'b0 || door_open !== (j < DC)) begin
        fails++;
        $display("FAIL call_here j=%0d: pend=%b door=%b expected pend=0 door=%b", j, pending, door_open, j < DC);
      end
      @(negedge clk);
    end
    wait_drain(20, "call_here");
    tests++;
    if (currentFl !== 3'd0 || pending !== 7'b0) begin
      fails++;
      $display("FAIL call_here_idle: fl=%0d pend=%b expected fl=0 pend=0", currentFl, pending);
    end
  endtask

  task automatic test_travel_up();
    int n;
    logic [2:0] exp_fl;
    @(negedge clk);
    call_req = 7'b0010000;
    n = cyc + 1;
    sb.push_back('{floor: 3'd4, rise: n + 4 * TC, len: DC});
    @(negedge clk);
    call_req = '0;
    for (int j = 0; j <= 4 * TC; j++) begin
      exp_fl = 3'(j / TC);
      tests++;
      if (currentFl !== exp_fl || moving_up !== (j < 4 * TC) || door_open !== (j == 4 * TC) ||
          pending[4] !== (j < 4 * TC) || moving_dn !== 1'b0) begin
        fails++;
        $display("FAIL travel_up j=%0d: fl=%0d up=%b door=%b pend4=%b dn=%b expected fl=%0d up=%b door=%b pend4=%b dn=0",
                 j, currentFl, moving_up, door_open, pending[4], moving_dn,
                 exp_fl, j < 4 * TC, j == 4 * TC, j < 4 * TC);
      end
      @(negedge clk);
    end
    wait_drain(20, "travel_up");
  endtask

  task automatic test_scan_order();
    int n;
    do_reset();
    @(negedge clk);
    call_req = 7'b0100000;
    n = cyc + 1;
    @(negedge clk);
    call_req = '0;
    repeat (8) @(negedge clk);
    tests++;
    if (currentFl !== 3'd2 || moving_up !== 1'b1) begin
      fails++;
      $display("FAIL scan_midway: fl=%0d up=%b expected fl=2 up=1", currentFl, moving_up);
    end
    call_req = 7'b0001010;
    sb.push_back('{floor: 3'd3, rise: n + 12, len: DC});
    sb.push_back('{floor: 3'd5, rise: n + 23, len: DC});
    sb.push_back('{floor: 3'd1, rise: n + 42, len: DC});
    @(negedge clk);
    call_req = '0;
    tests++;
    if (pending !== 7'b0101010) begin
      fails++;
      $display("FAIL scan_latch: pend=%b expected 0101010", pending);
    end
    wait_drain(80, "scan_order");
    tests++;
    if (currentFl !== 3'd1 || pending !== 7'b0) begin
      fails++;
      $display("FAIL scan_final: fl=%0d pend=%b expected fl=1 pend=0", currentFl, pending);
    end
  endtask

  task automatic test_door_hold();
    int n;
    @(negedge clk);
    call_req = 7'b0001000;
    n = cyc + 1;
    sb.push_back('{floor: 3'd3, rise: n + 2 * TC, len: 5 + DC});
    @(negedge clk);
    call_req = '0;
    repeat (2 * TC) @(negedge clk);
    tests++;
    if (door_open !== 1'b1 || currentFl !== 3'd3) begin
      fails++;
      $display("FAIL hold_arrive: door=%b fl=%0d expected door=1 fl=3", door_open, currentFl);
    end
    for (int k = 0; k < 5; k++) begin
      call_req = 7'b0001000;
      @(negedge clk);
      tests++;
      if (pending[3] !== 1'b0 || door_open !== 1'b1) begin
        fails++;
        $display("FAIL hold_k%0d: pend3=%b door=%b expected pend3=0 door=1", k, pending[3], door_open);
      end
    end
    call_req = '0;
    wait_drain(20, "door_hold");
  endtask

  task automatic test_reset_mid_travel();
    do_reset();
    @(negedge clk);
    call_req = 7'b1000000;
    @(negedge clk);
    call_req = '0;
    repeat (9) @(negedge clk);
    tests++;
    if (currentFl !== 3'd2 || moving_up !== 1'b1 || pending !== 7'b1000000) begin
      fails++;
      $display("FAIL midreset_pre: fl=%0d up=%b pend=%b expected fl=2 up=1 pend=1000000",
               currentFl, moving_up, pending);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (currentFl !== 3'd0 || pending !== 7'b0 || moving_up !== 1'b0 || door_open !== 1'b0) begin
      fails++;
      $display("FAIL midreset: fl=%0d pend=%b up=%b door=%b expected 0",
               currentFl, pending, moving_up, door_open);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if ({currentFl, pending, door_open, moving_up, moving_dn} !== '0) begin
      fails++;
      $display("FAIL midreset_after: fl=%0d pend=%b door=%b up=%b dn=%b expected all 0",
               currentFl, pending, door_open, moving_up, moving_dn);
    end
  endtask

  initial begin
    test_reset();
    test_call_here();
    test_travel_up();
    test_scan_order();
    test_door_hold();
    test_reset_mid_travel();
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: %0d expected door openings never seen", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
